// File: rtl/ucie_ctl_sb_deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : ucie_ctl_sb_pkg
//  Purpose   : Shared sideband word width, receive FSM states, beat helper.
//  Revision  : 1.0 - initial release
// ============================================================================
package ucie_ctl_sb_pkg;

    localparam int SB_WORD_W = 32;

    typedef enum logic [0:0] {
        SB_RX_IDLE    = 1'b0,
        SB_RX_COLLECT = 1'b1
    } sb_rx_state_t;

    function automatic int beats(input int n);
        return SB_WORD_W / n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucie_ctl_sb_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Interface : ucie_ctl_sb_deserializer_if
//  Purpose   : Link beat input and decoder-facing word handshake.
//  Revision  : 1.0 - initial release
// ============================================================================
interface ucie_ctl_sb_deserializer_if #(
    parameter int N = 16
);
    logic           i_rx_valid;
    logic           i_rx_sof;
    logic [N-1:0]   i_rx_data;
    logic           o_word_valid;
    logic [31:0]    o_word;
    logic           i_word_ready;

    // Link and word consumer side
    modport master (
        output i_rx_valid,
        output i_rx_sof,
        output i_rx_data,
        input  o_word_valid,
        input  o_word,
        output i_word_ready
    );

    // Deserializer side
    modport slave (
        input  i_rx_valid,
        input  i_rx_sof,
        input  i_rx_data,
        output o_word_valid,
        output o_word,
        input  i_word_ready
    );
endinterface
`default_nettype wire

// File: rtl/ucie_ctl_sb_word_fifo.sv
`default_nettype none
// ============================================================================
//  Module    : ucie_ctl_sb_word_fifo
//  Purpose   : DEPTH x 32 word FIFO with registered head; push on full is
//              accepted only when a pop frees a slot in the same cycle.
//  Revision  : 1.0 - initial release
// ============================================================================
module ucie_ctl_sb_word_fifo
    import ucie_ctl_sb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_reset,
    input  wire logic                  push,
    input  wire logic [SB_WORD_W-1:0]  push_data,
    input  wire logic                  pop,
    output logic                       full,
    output logic                       empty,
    output logic [SB_WORD_W-1:0]       head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SB_WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/ucie_ctl_sb_deserializer.sv
`default_nettype none
// ============================================================================
//  Module    : ucie_ctl_sb_deserializer
//  Purpose   : Sideband RX deserializer; assembles 32/N LSB-first beats into
//              32-bit words and queues them for the packet decoder.
//  Revision  : 1.0 - initial release
// ============================================================================
module ucie_ctl_sb_deserializer
    import ucie_ctl_sb_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 2
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_reset,
    ucie_ctl_sb_deserializer_if.slave sb,
    output logic [2:0]                o_beat_cnt,
    output logic                      o_frame_err,
    output logic                      o_overflow,
    input  wire logic                 i_clr_err
);
    localparam int BEATS = beats(N);

    if (!(N == 4 || N == 8 || N == 16 || N == 32)) begin : g_bad_width
        $error("ucie_ctl_sb_deserializer: N must be 4, 8, 16 or 32");
    end

    sb_rx_state_t          state;
    sb_rx_state_t          state_n;
    logic [2:0]            cnt;
    logic [2:0]            cnt_n;
    logic [SB_WORD_W-1:0]  asm_word;
    logic [SB_WORD_W-1:0]  asm_n;
    logic                  frame_err;
    logic                  frame_err_n;
    logic                  overflow;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= SB_RX_IDLE;
            cnt       <= '0;
            asm_word  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            asm_word  <= asm_n;
            frame_err <= frame_err_n;
        end
    end

    // The pushed word is asm_n, so the final beat reaches the FIFO on the
    // same edge that samples it.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        asm_n       = asm_word;
        push        = 1'b0;
        frame_err_n = 1'b0;
        if (sb.i_rx_valid) begin
            case (state)
                SB_RX_IDLE: begin
                    if (sb.i_rx_sof) begin
                        asm_n        = '0;
                        asm_n[N-1:0] = sb.i_rx_data;
                        if (BEATS == 1) begin
                            push  = 1'b1;
                            cnt_n = 3'd0;
                        end else begin
                            cnt_n   = 3'd1;
                            state_n = SB_RX_COLLECT;
                        end
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
                SB_RX_COLLECT: begin
                    if (sb.i_rx_sof) begin
                        frame_err_n  = 1'b1;
                        asm_n        = '0;
                        asm_n[N-1:0] = sb.i_rx_data;
                        cnt_n        = 3'd1;
                    end else begin
                        asm_n[int'(cnt)*N +: N] = sb.i_rx_data;
                        if (cnt == 3'(BEATS-1)) begin
                            push    = 1'b1;
                            cnt_n   = 3'd0;
                            state_n = SB_RX_IDLE;
                        end else begin
                            cnt_n = cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state_n = SB_RX_IDLE;
                    cnt_n   = 3'd0;
                end
            endcase
        end
    end

    ucie_ctl_sb_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push      (push),
        .push_data (asm_n),
        .pop       (sb.i_word_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (sb.o_word)
    );

    // A full FIFO only has room if the consumer drains its head this cycle.
    assign drop = push & fifo_full & ~sb.i_word_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (i_clr_err) begin
            overflow <= 1'b0;
        end
    end

    assign sb.o_word_valid = ~fifo_empty;
    assign o_beat_cnt      = cnt;
    assign o_frame_err     = frame_err;
    assign o_overflow      = overflow;
endmodule
`default_nettype wire
